// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: widths, reset defaults, opcodes and the fetch-side types.
// The fetch buffer stores the instruction together with its PC.
package rv_core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; the low two bits are simply dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decode and branch-feedback signals.
// The master side is the fetch unit; the slave side is memory plus decode/execute.
interface instr_fetch_unit_if;
    import rv_core_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            pcsrc;
    logic [XLEN-1:0] branch_target;
    logic            misalign_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready, pcsrc, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready, pcsrc, branch_target
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries between memory and decode.
// Clear wins over push/pop so a redirect discards everything, including a same-cycle response.
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: PC generation, credit-limited in-order fetch, buffering to decode,
// and branch redirect with discard of responses already in flight.
module instr_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;
    logic            redirect;
    logic            head_valid;
    logic            fifo_empty;
    logic            misalign_q;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign accept      = bus.imem_req & bus.imem_ready;
    assign resp        = bus.imem_rvalid;
    assign head_valid  = !fifo_empty;
    assign pop         = head_valid & bus.instr_ready;
    assign redirect    = pop & bus.pcsrc;
    assign push        = resp & (state == ST_RUN) & !redirect;
    assign push_entry  = '{pc: resp_pc, instr: bus.imem_rdata};

    always_comb begin
        inflight_next = inflight;
        if (accept && !resp) begin
            inflight_next = inflight + CW'(1);
        end else if (!accept && resp) begin
            inflight_next = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A request accepted on the redirect edge was for the old path, so it joins the drop count.
    always_comb begin
        state_next   = state;
        bus.imem_req = 1'b0;
        case (state)
            ST_RUN: begin
                bus.imem_req = rst_n && (credit_used < (CW+1)'(DEPTH));
                if (redirect && (inflight_next != '0)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (resp && (drop_cnt == CW'(1))) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            misalign_q <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                fetch_pc <= word_align(bus.branch_target);
                resp_pc  <= word_align(bus.branch_target);
                drop_cnt <= inflight_next;
                if (bus.branch_target[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if ((state == ST_FLUSH) && resp) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.imem_addr    = fetch_pc;
    assign bus.instr_valid  = head_valid;
    assign bus.instr        = head_valid ? head.instr : '0;
    assign bus.instr_pc     = head_valid ? head.pc : '0;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory with random latency, random decode stalls and
// redirects, checked every cycle against a queue-based model of requests and buffered words.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } word_t;

    logic clk;
    logic rst_n;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    req_t        pend[$];
    word_t       fifo_q[$];
    logic [31:0] m_pc;
    bit          m_mis;
    int          cyc;
    int          total;
    int          bad;
    int          delivered;
    int          p_ready;
    int          p_iready;
    int          p_pcsrc;
    int          max_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pickTarget();
        int sel = $urandom_range(3);
        if (sel == 0) return 32'h0000_0100;
        if (sel == 1) return 32'h0000_0102;
        return $urandom;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        pend.delete();
        fifo_q.delete();
        m_pc  = RST_PC;
        m_mis = 1'b0;
    endtask

    task automatic driveIdle();
        bus.imem_ready    = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.instr_ready   = 1'b0;
        bus.pcsrc         = 1'b0;
        bus.branch_target = '0;
    endtask

    // Reset is asserted between edges; outputs must clear without waiting for a clock.
    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        driveIdle();
        #1;
        modelReset();
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'h0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rst_instr", bus.instr, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_misalign", 32'(bus.misalign_err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input bit force_redir, input logic [31:0] force_tgt);
        bit    rv;
        bit    acc;
        bit    pop;
        bit    redir;
        bit    exp_req;
        bit    exp_valid;
        bit    any_stale;
        req_t  r;
        req_t  e;
        @(negedge clk);
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.imem_ready    = ($urandom_range(99) < p_ready);
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rv ? memWord(pend[0].addr) : $urandom;
        bus.instr_ready   = force_redir ? 1'b1 : ($urandom_range(99) < p_iready);
        bus.pcsrc         = force_redir ? 1'b1 : ($urandom_range(99) < p_pcsrc);
        bus.branch_target = force_redir ? force_tgt : pickTarget();
        #1;
        any_stale = 1'b0;
        foreach (pend[i]) if (pend[i].stale) any_stale = 1'b1;
        exp_req   = !any_stale && ((pend.size() + fifo_q.size()) < DEPTH);
        exp_valid = (fifo_q.size() > 0);
        checkOutput("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) checkOutput("imem_addr", bus.imem_addr, m_pc);
        checkOutput("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("instr", bus.instr, fifo_q[0].instr);
            checkOutput("instr_pc", bus.instr_pc, fifo_q[0].pc);
        end
        checkOutput("misalign_err", 32'(bus.misalign_err), 32'(m_mis));

        acc   = exp_req && bus.imem_ready;
        pop   = exp_valid && bus.instr_ready;
        redir = pop && bus.pcsrc;
        if (pop) begin
            void'(fifo_q.pop_front());
            delivered++;
        end
        if (rv) begin
            e = pend.pop_front();
            if (!e.stale && !redir) fifo_q.push_back('{e.pc, memWord(e.pc)});
        end
        if (redir) begin
            fifo_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
        end
        if (acc) begin
            r.addr  = bus.imem_addr;
            r.pc    = m_pc;
            r.due   = cyc + $urandom_range(max_lat, 1);
            r.stale = redir;
            pend.push_back(r);
        end
        if (redir) begin
            m_pc = bus.branch_target & 32'hFFFF_FFFC;
            if (bus.branch_target[1:0] != 2'b00) m_mis = 1'b1;
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    // Waits a bounded number of cycles for a valid head, then takes a redirect on it.
    task automatic redirectTo(input logic [31:0] tgt);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (fifo_q.size() > 0) begin
                applyStimulus(1'b1, tgt);
                done = 1'b1;
            end else begin
                applyStimulus(1'b0, '0);
            end
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL redirect_window observed=0 expected=1 target=%h", tgt);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        delivered = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        driveIdle();
        modelReset();

        $display("[TB] reset and streaming fetch across the address wrap");
        pulseReset();
        p_ready = 100; p_iready = 100; p_pcsrc = 0; max_lat = 1;
        repeat (20) applyStimulus(1'b0, '0);

        $display("[TB] decode stall then release");
        p_iready = 0;
        repeat (10) applyStimulus(1'b0, '0);
        p_iready = 100;
        repeat (10) applyStimulus(1'b0, '0);

        $display("[TB] directed redirects to aligned and misaligned targets");
        redirectTo(32'h0000_0100);
        repeat (8) applyStimulus(1'b0, '0);
        max_lat = 3;
        redirectTo(32'h0000_0102);
        repeat (12) applyStimulus(1'b0, '0);

        $display("[TB] randomized traffic");
        p_ready = 70; p_iready = 60; p_pcsrc = 10; max_lat = 3;
        repeat (300) applyStimulus(1'b0, '0);

        $display("[TB] reset pulsed mid-stream");
        pulseReset();
        repeat (60) applyStimulus(1'b0, '0);

        total++;
        assert (delivered > 40) else begin
            bad++;
            $error("FAIL delivered_count observed=%0d expected=>40", delivered);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
